// File: rtl/inc16.sv
// Registered 16-bit incrementer built from a half-adder ripple chain.
// Define INC16_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module inc16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_a,
    output logic        out_valid,
    output logic [15:0] out,
    output logic        carry
`ifdef INC16_OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    logic [16:0] c;
    logic [15:0] sum;

    // Carry-in of one makes the chain an incrementer.
    always_comb begin
        c      = '0;
        sum    = '0;
        c[0]   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sum[i]   = in_a[i] ^ c[i];
            c[i + 1] = in_a[i] & c[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= sum;
                carry <= c[16];
            end
        end
    end

`ifdef INC16_OVF_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ~in_a[15] & sum[15];
        end
    end
`endif

endmodule

// File: tb/tb_inc16.sv
// Directed self-checking bench for inc16, plus an exhaustive operand sweep.
// Overflow checks are active when INC16_OVF_FLAG_EN is defined.
module tb_inc16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic        out_valid;
    logic [15:0] out;
    logic        carry;
`ifdef INC16_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int failures = 0;

    inc16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out       (out),
        .carry     (carry)
`ifdef INC16_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [15:0] a);
        @(negedge clk);
        in_valid = v;
        in_a     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] exp_out,
                           input logic exp_vld, input logic exp_cy,
                           input logic exp_ovf);
        chk({tag, ".out"}, 32'(out), 32'(exp_out));
        chk({tag, ".vld"}, 32'(out_valid), 32'(exp_vld));
        chk({tag, ".cy"}, 32'(carry), 32'(exp_cy));
`ifdef INC16_OVF_FLAG_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] y;
        logic        cy;
        logic        ov;
    } vec_t;

    vec_t vecs[7] = '{
        '{16'd14,   16'd15,   1'b0, 1'b0},
        '{16'hFFC5, 16'hFFC6, 1'b0, 1'b0},
        '{16'hFB23, 16'hFB24, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0},
        '{16'h0000, 16'h0001, 1'b0, 1'b0},
        '{16'h7FFF, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h8001, 1'b0, 1'b0}
    };

    initial begin
        int bad;
        logic [15:0] exp_y;
        logic [16:0] wide;

        rst_n = 1'b0;
        step(1'b1, 16'h1234);
        step(1'b1, 16'h1234);
        chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a);
            chk_res($sformatf("v%0d", i), vecs[i].y, 1'b1,
                    vecs[i].cy, vecs[i].ov);
        end

        step(1'b1, 16'd100);
        chk_res("hold0", 16'd101, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'hFFFF);
            chk_res($sformatf("hold%0d", k + 1), 16'd101, 1'b0, 1'b0, 1'b0);
        end

        step(1'b1, 16'd500);
        chk_res("mid0", 16'd501, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 16'd600);
        chk_res("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 16'd7);
        chk_res("mid_rel", 16'd8, 1'b1, 1'b0, 1'b0);

        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 16'(i));
            wide  = 17'(i) + 17'd1;
            exp_y = wide[15:0];
            if (out !== exp_y || out_valid !== 1'b1 ||
                carry !== (i == 65535))
                bad++;
`ifdef INC16_OVF_FLAG_EN
            if (ovf !== (i == 32767))
                bad++;
`endif
        end
        chk("exhaustive", 32'(bad), 32'd0);

        step(1'b0, 16'h0000);
        chk("exh_tail.vld", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inc16.md
# inc16

Registered 16-bit incrementer: accepts a 16-bit two's-complement word and returns word + 1, modulo 2^16. It is the increment primitive of the Hack hardware platform, feeding the program counter and the ALU support logic. It sits after the 16-bit adder family and is built from a ripple chain of half adders, with one register stage on the output.

## Interface
- No parameters; width fixed at 16 bits.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  `in_a` is captured on this rising edge.
- in_a  input  16  operand, two's complement or unsigned; the interpretation is irrelevant to the sum.
- out_valid  output  1  `out` holds a fresh result.
- out  output  16  registered `in_a + 1`, modulo 2^16.
- carry  output  1  registered unsigned carry-out; 1 only when `in_a` = 16'hFFFF.
- ovf  output  1  registered signed overflow; 1 only when `in_a` = 16'h7FFF. Present only under the configuration macro.

## Operation
- Combinational core: a 16-stage half-adder ripple chain.
  - Carry-in to bit 0 is constant 1.
  - sum[i] = a[i] XOR c[i]; c[i+1] = a[i] AND c[i].
  - carry = c[16].
- Signed overflow = in_a[15]==0 AND sum[15]==1.
- Wrap-around:
  - 16'hFFFF (-1) gives 16'h0000, carry=1, ovf=0.
  - 16'h7FFF (32767) gives 16'h8000 (-32768), carry=0, ovf=1.
- Pure function of `in_a`; no internal state besides the output registers.
- When `in_valid`=0, `out`, `carry` and `ovf` hold their previous values and `out_valid` goes to 0.
- No back-pressure; a new operand can be accepted every cycle.

## Timing
- Latency is exactly 1 cycle. An operand sampled at edge N with `in_valid`=1 appears at edge N, and is stable through the cycle before edge N+1.
- `out_valid` is 1 in exactly the cycle following each accepted operand.
- Throughput: 1 result per cycle.
- Reset has priority over `in_valid`. With `rst_n`=0 at a rising edge, all outputs become 0 on that edge:
  - out=16'h0000, out_valid=0, carry=0, ovf=0.
- An operand presented in the same cycle as reset is discarded.
- Reset mid-stream drops any pending result. The first operand after reset is accepted on the first edge where `rst_n`=1.
- The ripple chain has a 16-stage carry path and must close timing within one clock period.

## Configuration
- Macro: INC16_OVF_FLAG_EN.
- Defined:
  - the `ovf` port and its register exist;
  - `ovf` is updated together with `out`.
- Undefined:
  - the `ovf` port is absent and no overflow logic is built;
  - `out`, `carry`, `out_valid` and latency are unchanged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_a=16'h1234 and in_valid=1 -> out=0, out_valid=0, carry=0, ovf=0.
- Signed sequence, one operand per cycle (in_valid=1): 14, -59, -1245, -1, 0 -> next-cycle out = 15, -58, -1244, 0, 1, with out_valid=1 each cycle. Carry=1 only for the -1 case.
- Boundaries:
  - in_a=16'h7FFF -> out=16'h8000, ovf=1 (macro defined), carry=0.
  - in_a=16'h8000 -> out=16'h8001, ovf=0.
- Hold: accept in_a=100, then in_valid=0 for 3 cycles -> out stays 101 and out_valid=0 after the first result cycle.
- Reset mid-stream: accept 500, assert rst_n=0 on the following edge -> outputs 0. Release reset and accept 7 -> out=8 one cycle later.
- Exhaustive: all 65536 operands back-to-back -> every out == (in_a+1) mod 65536. Carry and ovf set only at 16'hFFFF and 16'h7FFF respectively.
